// File: rtl/adv7511_cfg_pkg.sv
// Shared types and the ADV7511 bring-up register table for the HDMI transmitter I2C configurator.
package adv7511_cfg_pkg;

   localparam int unsigned NUM_ENTRIES     = 13;
   localparam int unsigned TICKS_PER_ENTRY = 120;
   localparam logic [3:0]  LAST_INDEX      = 4'(NUM_ENTRIES - 1);

   typedef struct packed {
      logic [7:0] reg_addr;
      logic [7:0] reg_data;
   } cfg_entry_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_HPD,
      ST_START,
      ST_BYTE,
      ST_STOP,
      ST_GAP,
      ST_DONE,
      ST_ERROR
   } cfg_state_t;

   typedef enum logic [1:0] {
      CMD_START,
      CMD_WRITE,
      CMD_STOP,
      CMD_GAP
   } i2c_cmd_t;

   localparam cfg_entry_t CFG_TABLE [NUM_ENTRIES] = '{
      '{8'h41, 8'h10}, '{8'h98, 8'h03}, '{8'h9A, 8'hE0}, '{8'h9C, 8'h30},
      '{8'h9D, 8'h61}, '{8'hA2, 8'hA4}, '{8'hA3, 8'hA4}, '{8'hE0, 8'hD0},
      '{8'hAF, 8'h06}, '{8'hF9, 8'h00}, '{8'h15, 8'h01}, '{8'h16, 8'h38},
      '{8'h48, 8'h08}
   };

   function automatic cfg_entry_t cfg_entry(input logic [3:0] idx);
      if (idx <= LAST_INDEX) cfg_entry = CFG_TABLE[idx];
      else                   cfg_entry = '0;
   endfunction

endpackage

// File: rtl/i2c_byte_master.sv
// Quarter-tick I2C bit engine: runs START / byte write / STOP / bus-free GAP phases back to back.
module i2c_byte_master
   import adv7511_cfg_pkg::*;
#(
   parameter int unsigned CLK_DIV = 375
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  i2c_cmd_t   cmd,
   input  logic [7:0] cmd_data,
   input  logic       sda_i,
   output logic       scl_oe,
   output logic       sda_oe,
   output logic       ready,
   output logic       nack,
   output logic       active
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic             last_bit;
   i2c_cmd_t         cur_cmd;
   i2c_cmd_t         pend_cmd;
   logic             pend_valid;
   logic [7:0]       shreg;
   logic [7:0]       pend_data;
   logic [1:0]       qtr;
   logic [3:0]       bit_cnt;
   logic             scl_drv_c;
   logic             sda_drv_c;

   assign tick     = active && (div_cnt == DIV_W'(CLK_DIV - 1));
   assign last_bit = (cur_cmd != CMD_WRITE) || (bit_cnt == 4'd8);

   // ready fires entering the final quarter so the next command is queued before the phase ends
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt    <= '0;
         active     <= 1'b0;
         cur_cmd    <= CMD_GAP;
         pend_cmd   <= CMD_GAP;
         pend_valid <= 1'b0;
         shreg      <= '0;
         pend_data  <= '0;
         qtr        <= '0;
         bit_cnt    <= '0;
         ready      <= 1'b0;
         nack       <= 1'b0;
      end else begin
         ready <= 1'b0;
         if (!active) begin
            div_cnt <= '0;
            if (cmd_valid) begin
               active     <= 1'b1;
               cur_cmd    <= cmd;
               shreg      <= cmd_data;
               pend_valid <= 1'b0;
               qtr        <= '0;
               bit_cnt    <= '0;
            end
         end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (cmd_valid) begin
               pend_valid <= 1'b1;
               pend_cmd   <= cmd;
               pend_data  <= cmd_data;
            end
            if (tick) begin
               if (qtr == 2'd3) begin
                  qtr <= '0;
                  if (!last_bit) begin
                     bit_cnt <= bit_cnt + 4'd1;
                     shreg   <= {shreg[6:0], 1'b0};
                  end else if (pend_valid) begin
                     cur_cmd    <= pend_cmd;
                     shreg      <= pend_data;
                     pend_valid <= 1'b0;
                     bit_cnt    <= '0;
                  end else begin
                     active <= 1'b0;
                  end
               end else begin
                  qtr <= qtr + 2'd1;
                  if (qtr == 2'd2 && last_bit) begin
                     ready <= 1'b1;
                     nack  <= (cur_cmd == CMD_WRITE) && sda_i;
                  end
               end
            end
         end
      end
   end

   // Line levels per phase and quarter (1 = pull low)
   always_comb begin
      scl_drv_c = 1'b0;
      sda_drv_c = 1'b0;
      if (active) begin
         case (cur_cmd)
            CMD_START: sda_drv_c = qtr[1];
            CMD_WRITE: begin
               scl_drv_c = !qtr[1];
               sda_drv_c = (bit_cnt == 4'd8) ? 1'b0 : !shreg[7];
            end
            CMD_STOP: begin
               scl_drv_c = (qtr == 2'd0);
               sda_drv_c = (qtr != 2'd3);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_oe <= 1'b0;
         sda_oe <= 1'b0;
      end else begin
         scl_oe <= scl_drv_c;
         sda_oe <= sda_drv_c;
      end
   end

endmodule

// File: rtl/adv7511_i2c_config.sv
// ADV7511 bring-up sequencer: writes the register table over I2C after hot-plug detect.
module adv7511_i2c_config
   import adv7511_cfg_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 375,
   parameter logic [7:0]  DEV_ADDR = 8'h72
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hpd,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic       scl_oe,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [3:0] reg_index
);

   logic       hpd_meta;
   logic       hpd_sync;
   cfg_state_t state;
   cfg_state_t state_next;
   logic [3:0] reg_index_next;
   logic [1:0] byte_cnt;
   logic [1:0] byte_cnt_next;
   logic       nack_seen;
   logic       nack_seen_next;
   logic       cmd_valid_c;
   i2c_cmd_t   cmd_c;
   logic [7:0] cmd_data_c;
   logic       m_ready;
   logic       m_nack;
   logic       m_active;

   function automatic logic [7:0] entry_byte(input logic [3:0] idx, input logic [1:0] sel);
      cfg_entry_t e;
      e = cfg_entry(idx);
      case (sel)
         2'd0:    entry_byte = DEV_ADDR;
         2'd1:    entry_byte = e.reg_addr;
         default: entry_byte = e.reg_data;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         hpd_meta  <= 1'b0;
         hpd_sync  <= 1'b0;
         reg_index <= '0;
         byte_cnt  <= '0;
         nack_seen <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_next;
         hpd_meta  <= hpd;
         hpd_sync  <= hpd_meta;
         reg_index <= reg_index_next;
         byte_cnt  <= byte_cnt_next;
         nack_seen <= nack_seen_next;
         busy      <= state_next inside {ST_START, ST_BYTE, ST_STOP, ST_GAP};
         done      <= (state_next == ST_DONE);
         error     <= (state_next == ST_ERROR);
      end
   end

   // Each master ready both advances the sequence and queues the following phase
   always_comb begin
      state_next     = state;
      reg_index_next = reg_index;
      byte_cnt_next  = byte_cnt;
      nack_seen_next = nack_seen;
      cmd_valid_c    = 1'b0;
      cmd_c          = CMD_GAP;
      cmd_data_c     = '0;
      case (state)
         ST_IDLE: state_next = ST_WAIT_HPD;
         ST_WAIT_HPD: begin
            reg_index_next = '0;
            if (hpd_sync) begin
               state_next  = ST_START;
               cmd_valid_c = 1'b1;
               cmd_c       = CMD_START;
            end
         end
         ST_START: begin
            if (m_ready) begin
               state_next    = ST_BYTE;
               byte_cnt_next = '0;
               cmd_valid_c   = 1'b1;
               cmd_c         = CMD_WRITE;
               cmd_data_c    = entry_byte(reg_index, 2'd0);
            end
         end
         ST_BYTE: begin
            if (m_ready) begin
               cmd_valid_c = 1'b1;
               if (m_nack || byte_cnt == 2'd2) begin
                  nack_seen_next = nack_seen || m_nack;
                  state_next     = ST_STOP;
                  cmd_c          = CMD_STOP;
               end else begin
                  byte_cnt_next = byte_cnt + 2'd1;
                  cmd_c         = CMD_WRITE;
                  cmd_data_c    = entry_byte(reg_index, byte_cnt + 2'd1);
               end
            end
         end
         ST_STOP: begin
            if (m_ready) begin
               state_next  = ST_GAP;
               cmd_valid_c = 1'b1;
               cmd_c       = CMD_GAP;
            end
         end
         ST_GAP: begin
            if (m_ready) begin
               if (hpd_sync && !nack_seen && reg_index != LAST_INDEX) begin
                  reg_index_next = reg_index + 4'd1;
                  state_next     = ST_START;
                  cmd_valid_c    = 1'b1;
                  cmd_c          = CMD_START;
               end
            end else if (!m_active) begin
               if (nack_seen) begin
                  state_next = ST_ERROR;
               end else if (hpd_sync && reg_index == LAST_INDEX) begin
                  state_next = ST_DONE;
               end else begin
                  state_next     = ST_WAIT_HPD;
                  reg_index_next = '0;
               end
            end
         end
         ST_DONE: begin
            if (!hpd_sync) begin
               state_next     = ST_WAIT_HPD;
               reg_index_next = '0;
            end
         end
         ST_ERROR: state_next = ST_ERROR;
         default:  state_next = ST_IDLE;
      endcase
   end

   i2c_byte_master #(
      .CLK_DIV (CLK_DIV)
   ) u_master (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid_c),
      .cmd       (cmd_c),
      .cmd_data  (cmd_data_c),
      .sda_i     (sda_i),
      .scl_oe    (scl_oe),
      .sda_oe    (sda_oe),
      .ready     (m_ready),
      .nack      (m_nack),
      .active    (m_active)
   );

endmodule
